// File: rtl/lbus_seq_if.sv
`default_nettype none
// ============================================================================
// lbus_seq_if : requester handshakes and card-side bus pins of lbus_seq
// Rev 1.0
// ============================================================================
interface lbus_seq_if;
    logic       req0, req1;
    logic       rnw0, rnw1;
    logic       dev0, dev1;
    logic [9:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1;
    logic [7:0] rdata;
    logic [7:0] bd_in;
    logic [7:0] bd_out;
    logic       bd_oe;
    logic       brd_n, bwr_n;
    logic       w5300_cs_n;
    logic [9:0] w5300_addr;
    logic       sl811_cs_n;
    logic       sl811_a0;
    logic       busy;

    modport slave (
        input  req0, req1, rnw0, rnw1, dev0, dev1, addr0, addr1,
               wdata0, wdata1, bd_in,
        output ack0, ack1, rdata, bd_out, bd_oe, brd_n, bwr_n,
               w5300_cs_n, w5300_addr, sl811_cs_n, sl811_a0, busy
    );

    modport master (
        output req0, req1, rnw0, rnw1, dev0, dev1, addr0, addr1,
               wdata0, wdata1, bd_in,
        input  ack0, ack1, rdata, bd_out, bd_oe, brd_n, bwr_n,
               w5300_cs_n, w5300_addr, sl811_cs_n, sl811_a0, busy
    );
endinterface
`default_nettype wire

// File: rtl/lbus_seq.sv
`default_nettype none
// ============================================================================
// lbus_seq : two-requester local-bus arbiter and W5300/SL811 cycle sequencer
// Rev 1.0
// ============================================================================
module lbus_seq #(
    parameter int SETUP_CYC = 1,
    parameter int W_STB_CYC = 2,
    parameter int S_STB_CYC = 3,
    parameter int HOLD_CYC  = 1
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    lbus_seq_if.slave  bus
);

    // Phase counters count down to zero, so they load length-1 (0 treated as 1).
    function automatic logic [3:0] load_val(input int n);
        if (n <= 1)       return 4'd0;
        else if (n > 15)  return 4'd14;
        else              return 4'(n - 1);
    endfunction

    localparam logic [3:0] SETUP_LD = load_val(SETUP_CYC);
    localparam logic [3:0] WSTB_LD  = load_val(W_STB_CYC);
    localparam logic [3:0] SSTB_LD  = load_val(S_STB_CYC);
    localparam logic [3:0] HOLD_LD  = load_val(HOLD_CYC);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TURN   = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       gnt_pend_q, gnt_q, last_grant_q, prev_rd_q;
    logic       rnw_q, dev_q;
    logic [9:0] addr_q;
    logic [7:0] wdata_q;
    logic       ack0_q, ack1_q;
    logic [7:0] rdata_q, bd_out_q;
    logic [9:0] w5300_addr_q;
    logic       sl811_a0_q;

    logic       w_arb, w_win, w_launch, w_last_hold, w_active;

    always_comb begin
        w_win       = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
        w_arb       = (state_q == IDLE) && !gnt_pend_q && (bus.req0 || bus.req1);
        w_launch    = (state_q == IDLE) && gnt_pend_q;
        w_last_hold = (state_q == HOLD) && (cnt_q == 4'd0);
        w_active    = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            gnt_pend_q   <= 1'b0;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            prev_rd_q    <= 1'b0;
            rnw_q        <= 1'b1;
            dev_q        <= 1'b0;
            addr_q       <= 10'd0;
            wdata_q      <= 8'd0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata_q      <= 8'd0;
            bd_out_q     <= 8'd0;
            w5300_addr_q <= 10'd0;
            sl811_a0_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack0_q  <= w_last_hold && !gnt_q;
            ack1_q  <= w_last_hold &&  gnt_q;
            if (w_arb) begin
                gnt_pend_q   <= 1'b1;
                gnt_q        <= w_win;
                last_grant_q <= w_win;
                rnw_q        <= w_win ? bus.rnw1   : bus.rnw0;
                dev_q        <= w_win ? bus.dev1   : bus.dev0;
                addr_q       <= w_win ? bus.addr1  : bus.addr0;
                wdata_q      <= w_win ? bus.wdata1 : bus.wdata0;
            end else begin
                gnt_pend_q   <= 1'b0;
            end
            if (w_launch) begin
                if (dev_q) sl811_a0_q   <= addr_q[0];
                else       w5300_addr_q <= addr_q;
                if (!rnw_q) bd_out_q <= wdata_q;
            end
            // Capture on the edge where the read strobe rises.
            if ((state_q == STROBE) && (cnt_q == 4'd0) && rnw_q)
                rdata_q <= bus.bd_in;
            if (w_last_hold)
                prev_rd_q <= rnw_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_pend_q) begin
                    if (prev_rd_q && !rnw_q) begin
                        state_d = TURN;
                    end else begin
                        state_d = SETUP;
                        cnt_d   = SETUP_LD;
                    end
                end
            end
            TURN: begin
                state_d = SETUP;
                cnt_d   = SETUP_LD;
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = STROBE;
                    cnt_d   = dev_q ? SSTB_LD : WSTB_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ack0       = ack0_q;
        bus.ack1       = ack1_q;
        bus.rdata      = rdata_q;
        bus.bd_out     = bd_out_q;
        bus.bd_oe      = w_active && !rnw_q;
        bus.brd_n      = !((state_q == STROBE) &&  rnw_q);
        bus.bwr_n      = !((state_q == STROBE) && !rnw_q);
        bus.w5300_cs_n = !(w_active && !dev_q);
        bus.sl811_cs_n = !(w_active &&  dev_q);
        bus.w5300_addr = w5300_addr_q;
        bus.sl811_a0   = sl811_a0_q;
        bus.busy       = (state_q != IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_lbus_seq.sv
`default_nettype none
// ============================================================================
// tb_lbus_seq : randomized self-checking bench for lbus_seq
// Rev 1.0
// ============================================================================
module tb_lbus_seq;

    localparam int P_SET  = 1;
    localparam int P_WSTB = 2;
    localparam int P_SSTB = 3;
    localparam int P_HOLD = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lbus_seq_if bus ();

    lbus_seq #(
        .SETUP_CYC (P_SET),
        .W_STB_CYC (P_WSTB),
        .S_STB_CYC (P_SSTB),
        .HOLD_CYC  (P_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Edge counter plus history of strobe/output-enable seen before each edge.
    int   cyc        = 0;
    int   brd_hi_run = 0;
    logic prev_oe    = 1'b0;
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        brd_hi_run <= (bus.brd_n === 1'b1) ? brd_hi_run + 1 : 0;
        prev_oe    <= bus.bd_oe;
    end

    // Reference model: round-robin owner, previous direction, last ack edge.
    int m_last_g   = 1;
    bit m_prev_rd  = 1'b0;
    int m_last_ack = -100;

    bit         t_rnw [2];
    bit         t_dev [2];
    logic [9:0] t_addr[2];
    logic [7:0] t_wd  [2];
    logic [7:0] t_rd  [2];

    function automatic int stb_len(input bit dev);
        return dev ? P_SSTB : P_WSTB;
    endfunction

    task automatic drive_fields();
        bus.rnw0 = t_rnw[0]; bus.dev0 = t_dev[0]; bus.addr0 = t_addr[0]; bus.wdata0 = t_wd[0];
        bus.rnw1 = t_rnw[1]; bus.dev1 = t_dev[1]; bus.addr1 = t_addr[1]; bus.wdata1 = t_wd[1];
    endtask

    task automatic scramble(input int k);
        if (k == 0) {bus.rnw0, bus.dev0, bus.addr0, bus.wdata0} = 20'($urandom());
        else        {bus.rnw1, bus.dev1, bus.addr1, bus.wdata1} = 20'($urandom());
    endtask

    task automatic randomize_fields();
        for (int i = 0; i < 2; i++) begin
            t_rnw[i]  = 1'($urandom_range(0, 1));
            t_dev[i]  = 1'($urandom_range(0, 1));
            t_addr[i] = 10'($urandom());
            t_wd[i]   = 8'($urandom());
            t_rd[i]   = 8'($urandom());
        end
    endtask

    // mode 0: req0 only, 1: req1 only, 2: both in the same cycle
    task automatic run_iter(input int mode);
        int order[2];
        int exp_edge[2];
        int gnt_edge[2];
        int n, g, lat, idx, nb_rd, nb_wr, budget, cur;
        if (mode == 2) begin
            order[0] = (m_last_g == 0) ? 1 : 0;
            order[1] = 1 - order[0];
            n = 2;
        end else begin
            order[0] = mode;
            order[1] = mode;
            n = 1;
        end
        @(negedge clk);
        drive_fields();
        bus.bd_in = t_rd[order[0]];
        bus.req0  = (mode != 1);
        bus.req1  = (mode != 0);
        for (int i = 0; i < n; i++) begin
            g   = (cyc + 1 > m_last_ack + 1) ? cyc + 1 : m_last_ack + 1;
            lat = P_SET + stb_len(t_dev[order[i]]) + P_HOLD + 1
                + ((m_prev_rd && !t_rnw[order[i]]) ? 1 : 0);
            gnt_edge[i] = g;
            exp_edge[i] = g + lat;
            m_prev_rd   = t_rnw[order[i]];
            m_last_g    = order[i];
            m_last_ack  = g + lat;
        end
        idx = 0; nb_rd = 0; nb_wr = 0; budget = 0;
        while (idx < n && budget < 80) begin
            @(negedge clk);
            budget++;
            cur = order[idx];
            if (!bus.brd_n) nb_rd++;
            if (!bus.bwr_n) nb_wr++;
            check_val("cs_excl", 32'(bus.w5300_cs_n | bus.sl811_cs_n), 1);
            check_val("oe_during_rd", 32'(bus.bd_oe & ~bus.brd_n), 0);
            check_val("strobe_excl", 32'(bus.brd_n | bus.bwr_n), 1);
            if (!bus.w5300_cs_n) begin
                check_val("w5300_sel_dev", 32'(t_dev[cur]), 0);
                check_val("w5300_addr", 32'(bus.w5300_addr), 32'(t_addr[cur]));
            end
            if (!bus.sl811_cs_n) begin
                check_val("sl811_sel_dev", 32'(t_dev[cur]), 1);
                check_val("sl811_a0", 32'(bus.sl811_a0), 32'(t_addr[cur][0]));
            end
            if (bus.bd_oe) begin
                check_val("oe_is_write", 32'(t_rnw[cur]), 0);
                check_val("bd_out", 32'(bus.bd_out), 32'(t_wd[cur]));
                if (!prev_oe) check_val("turn_gap", 32'(brd_hi_run >= 2), 1);
            end
            if (bus.ack0 || bus.ack1) begin
                check_val("ack_owner", 32'({bus.ack0, bus.ack1}), (cur == 1) ? 32'h1 : 32'h2);
                check_val("ack_edge", 32'(cyc), 32'(exp_edge[idx]));
                if (t_rnw[cur]) begin
                    check_val("rdata", 32'(bus.rdata), 32'(t_rd[cur]));
                    check_val("brd_len", 32'(nb_rd), 32'(stb_len(t_dev[cur])));
                    check_val("bwr_len", 32'(nb_wr), 0);
                end else begin
                    check_val("bwr_len", 32'(nb_wr), 32'(stb_len(t_dev[cur])));
                    check_val("brd_len", 32'(nb_rd), 0);
                end
                if (cur == 0) bus.req0 = 1'b0;
                else          bus.req1 = 1'b0;
                nb_rd = 0;
                nb_wr = 0;
                idx++;
                if (idx < n) bus.bd_in = t_rd[order[idx]];
            end else if (cyc >= gnt_edge[idx]) begin
                scramble(cur);
            end
        end
        if (idx < n) begin
            check_val("ack_timeout", 32'(idx), 32'(n));
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
        end
        @(negedge clk);
        check_val("ack_width", 32'({bus.ack0, bus.ack1}), 0);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.bd_in = 8'h00;
        for (int i = 0; i < 2; i++) begin
            t_rnw[i] = 1'b0; t_dev[i] = 1'b0; t_addr[i] = '0; t_wd[i] = '0; t_rd[i] = '0;
        end
        drive_fields();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check_val("rst_rdata", 32'(bus.rdata), 0);
        check_val("rst_bd_out", 32'(bus.bd_out), 0);
        check_val("rst_w5300_addr", 32'(bus.w5300_addr), 0);
        check_val("rst_sl811_a0", 32'(bus.sl811_a0), 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_val("idle_pins", 32'({bus.brd_n, bus.bwr_n, bus.w5300_cs_n, bus.sl811_cs_n,
                                        bus.bd_oe, bus.busy, bus.ack0, bus.ack1}), 32'hF0);
        end

        t_rnw[0] = 1'b0; t_dev[0] = 1'b0; t_addr[0] = 10'h2AB; t_wd[0] = 8'h5A;
        run_iter(0);
        t_rnw[1] = 1'b1; t_dev[1] = 1'b1; t_addr[1] = 10'h001; t_rd[1] = 8'hC3;
        run_iter(1);

        for (int i = 0; i < 2; i++) begin
            randomize_fields();
            run_iter(2);
        end

        t_rnw[1] = 1'b1; t_dev[1] = 1'b1; t_addr[1] = 10'h000; t_rd[1] = 8'h3C;
        run_iter(1);
        t_rnw[0] = 1'b0; t_dev[0] = 1'b0; t_addr[0] = 10'h155; t_wd[0] = 8'hA5;
        run_iter(0);

        for (int i = 0; i < 40; i++) begin
            randomize_fields();
            run_iter(int'($urandom_range(0, 2)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Reset during the second write-strobe cycle must abort without an ack.
        t_rnw[0] = 1'b0; t_dev[0] = 1'b0; t_addr[0] = 10'h0F0; t_wd[0] = 8'h99;
        @(negedge clk);
        drive_fields();
        bus.req0 = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 2; i++) begin
            @(negedge clk);
            if (!bus.bwr_n) cnt++;
        end
        check_val("abort_reach_strobe", 32'(cnt), 2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_val("abort_bwr_n", 32'(bus.bwr_n), 1);
        check_val("abort_cs_n", 32'(bus.w5300_cs_n), 1);
        check_val("abort_ack", 32'({bus.ack0, bus.ack1}), 0);
        bus.req0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("abort_quiet", 32'({bus.ack0, bus.ack1, bus.busy, bus.bd_oe}), 0);
        end
        rst_n = 1'b1;
        m_last_g   = 1;
        m_prev_rd  = 1'b0;
        m_last_ack = -100;
        randomize_fields();
        run_iter(2);
        randomize_fields();
        run_iter(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire

// File: doc/lbus_seq.md
Name: lbus_seq

Overview:
- Local-bus cycle sequencer and arbiter for the shared card-side bus: data bd, strobes brd_n/bwr_n, chip selects for W5300 and SL811.
- Two requesters share the bus:
  - Requester 0: Z80 decode path (memory window and ports).
  - Requester 1: autonomous poll/burst unit.
- Grants the bus to one requester at a time, generates chip-select, address and strobe timing with per-device strobe lengths, captures read data and acknowledges.
- Sits between the Z80 decode logic and the CPLD pins.

Parameters:
- SETUP_CYC, 1: cycles with address/CS valid before the strobe (1..15).
- W_STB_CYC, 2: strobe-low cycles for W5300 (1..15).
- S_STB_CYC, 3: strobe-low cycles for SL811 (1..15).
- HOLD_CYC, 1: cycles with address/CS/write data held after strobe release (1..15).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active low.
- req0, req1  in  1  request; held high until the matching ack.
- rnw0, rnw1  in  1  1 = read, 0 = write.
- dev0, dev1  in  1  0 = W5300, 1 = SL811.
- addr0, addr1  in  10  device address; SL811 uses bit 0 only.
- wdata0, wdata1  in  8  write data.
- ack0, ack1  out  1  one-cycle completion pulse.
- rdata  out  8  captured read data, shared by both requesters.
- bd_in  in  8  bus data from pins.
- bd_out  out  8  bus data to pins.
- bd_oe  out  1  bus output enable.
- brd_n, bwr_n  out  1  bus strobes.
- w5300_cs_n  out  1  W5300 chip select.
- w5300_addr  out  10  W5300 address.
- sl811_cs_n  out  1  SL811 chip select.
- sl811_a0  out  1  SL811 address/data select.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low at a clk edge) forces, on the next edge:
  - state IDLE, busy = 0.
  - brd_n = bwr_n = w5300_cs_n = sl811_cs_n = 1.
  - bd_oe = 0, ack0 = ack1 = 0.
  - rdata = 0, bd_out = 0, w5300_addr = 0, sl811_a0 = 0.
  - last_grant = 1, so requester 0 wins first.
- Reset mid-cycle aborts the cycle: strobes/CS released in one edge, no ack issued.
- States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE; TURN is inserted as described below.
- Arbitration happens only in IDLE and is registered; the grant takes effect on the next edge.
  - Only one requester asserted: it wins.
  - Both asserted: round-robin, the requester other than last_grant wins; last_grant updates on grant.
- Request lines are sampled once at grant. rnw/dev/addr/wdata are latched at grant; later changes are ignored until the next grant.
- SETUP (SETUP_CYC cycles):
  - Selected CS low, address driven: w5300_addr = addr, or sl811_a0 = addr[0].
  - Non-selected CS stays high and its address holds its previous value.
  - Write: bd_oe = 1, bd_out = wdata from SETUP through HOLD inclusive.
- STROBE (W_STB_CYC or S_STB_CYC cycles, by latched dev):
  - brd_n low for reads, bwr_n low for writes; never both low.
  - Read: rdata <= bd_in on the last STROBE cycle edge, i.e. the edge on which the strobe rises.
- HOLD (HOLD_CYC cycles): CS still low, strobes high. On the final HOLD edge:
  - CS goes high.
  - ack of the granted requester pulses high for exactly 1 cycle.
  - rdata is valid from that cycle until the next read capture.
- Latency from IDLE grant edge to ack: SETUP_CYC + STB + HOLD_CYC + 1 cycles.
  - Defaults: W5300 = 5 cycles, SL811 = 6 cycles.
- Back-to-back cycles:
  - A requester may reassert req in the ack cycle; arbitration restarts in IDLE on the following edge.
  - Minimum 1 IDLE cycle between cycles.
- TURN: if the previous cycle was a read and the next granted cycle is a write, 1 extra cycle with bd_oe = 0 and all CS high is inserted before SETUP.
- bd_oe is never 1 while brd_n = 0.
- If req drops before ack, the cycle still completes and ack still pulses (requester protocol violation, tolerated).
- Counters are 4 bit; a parameter value of 0 is illegal and is treated as 1.

Test Plan:
- Reset then idle: all CS/strobes high, bd_oe = 0, busy = 0, ack0 = ack1 = 0 for 20 cycles.
- req0 write, dev0 = 0, addr0 = 10'h2AB, wdata0 = 8'h5A:
  - w5300_addr = 2AB and bd_out = 5A through SETUP..HOLD.
  - bwr_n low for exactly 2 cycles.
  - ack0 pulses 5 cycles after grant.
  - sl811_cs_n stays 1.
- req1 read, dev1 = 1, addr1[0] = 1, bd_in = 8'hC3:
  - sl811_a0 = 1, brd_n low 3 cycles, bd_oe = 0 throughout.
  - rdata = C3 in the ack1 cycle.
- req0 and req1 asserted in the same cycle, repeatedly for 4 transactions: grants alternate 0, 1, 0, 1; no overlapping CS.
- SL811 read followed immediately by a W5300 write: TURN cycle present, bd_oe rises only after brd_n has been high for at least 2 cycles.
- rst_n asserted on the 2nd STROBE cycle of a write: bwr_n and CS high on the next edge, no ack, next request serviced normally after reset release.
